// File: rtl/req_queue_arbiter.sv
// Round-robin arbiter that merges NREQ request queues onto one dispatcher pull port.
// A queue is granted, it is pulled once, and then it is held until the dispatcher reports Done.
module req_queue_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Pwr_off,
    input  logic [NREQ-1:0] Empty,
    input  logic            PullEn,
    input  logic            Done,
    output logic [NREQ-1:0] Pull,
    output logic            IsEmpty,
    output logic [NREQ-1:0] Grant,
    output logic [IDW-1:0]  GrantId,
    output logic            Busy
);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t          state, state_next;
    logic [NREQ-1:0] grant_next;
    logic [IDW-1:0]  grant_id_next;
    logic [IDW-1:0]  last_id, last_id_next;
    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            clear;

    assign clear = Rst | Pwr_off;

    // Scan upward from the queue after the last one that completed.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_id) + k) % 32'(NREQ);
            if (!win_found && !Empty[idx[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = Grant;
        grant_id_next = GrantId;
        last_id_next  = last_id;
        Pull          = '0;
        IsEmpty       = 1'b1;
        Busy          = (state == BUSY);
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next    = GRANT;
                    grant_next    = ONE_HOT0 << win_id;
                    grant_id_next = win_id;
                end
            end
            GRANT: begin
                IsEmpty = Empty[GrantId];
                if (PullEn && !Empty[GrantId]) begin
                    Pull       = Grant;
                    state_next = BUSY;
                end else if (Empty[GrantId]) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            BUSY: begin
                if (Done) begin
                    last_id_next = GrantId;
                    state_next   = IDLE;
                    grant_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset masks the combinational outputs in the same cycle it is seen.
        if (clear) begin
            Pull    = '0;
            IsEmpty = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            state   <= IDLE;
            Grant   <= '0;
            GrantId <= '0;
            last_id <= IDW'(NREQ - 1);
        end else begin
            state   <= state_next;
            Grant   <= grant_next;
            GrantId <= grant_id_next;
            last_id <= last_id_next;
        end
    end

endmodule

// File: tb/tb_req_queue_arbiter.sv
// Randomized and directed checks of req_queue_arbiter against a cycle-level model
// that tracks only the granted queue, a busy flag and the last completed queue.
module tb_req_queue_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pwr_off = 1'b0;
    logic [NREQ-1:0] empty = '1;
    logic            pull_en = 1'b0;
    logic            done = 1'b0;
    logic [NREQ-1:0] pull;
    logic            is_empty;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    int nchecks = 0;
    int nerrors = 0;

    // Model state: granted queue (-1 when none), busy flag, last completed queue.
    int m_gnt  = -1;
    bit m_busy = 1'b0;
    int m_last = NREQ - 1;

    req_queue_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .Clk(clk), .Rst(rst), .Pwr_off(pwr_off), .Empty(empty), .PullEn(pull_en),
        .Done(done), .Pull(pull), .IsEmpty(is_empty), .Grant(grant),
        .GrantId(grant_id), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic [NREQ-1:0] e, input logic pe, input logic d,
                        input logic r, input logic p);
        logic [NREQ-1:0] exp_pull;
        logic [NREQ-1:0] exp_grant;
        logic            exp_ie;
        int              q;
        @(negedge clk);
        empty = e; pull_en = pe; done = d; rst = r; pwr_off = p;
        #1;
        exp_pull  = '0;
        exp_ie    = 1'b1;
        exp_grant = '0;
        if (m_gnt >= 0) exp_grant = NREQ'(1) << m_gnt;
        if (!(r || p) && m_gnt >= 0 && !m_busy) begin
            exp_ie = e[m_gnt];
            if (pe && !e[m_gnt]) exp_pull = NREQ'(1) << m_gnt;
        end
        check("pull", 32'(pull), 32'(exp_pull));
        check("is_empty", 32'(is_empty), 32'(exp_ie));
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_gnt >= 0) check("grant_id", 32'(grant_id), 32'(m_gnt));
        @(posedge clk);
        if (r || p) begin
            m_gnt = -1; m_busy = 1'b0; m_last = NREQ - 1;
        end else if (m_gnt < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                q = (m_last + k) % NREQ;
                if (m_gnt < 0 && !e[q]) m_gnt = q;
            end
        end else if (!m_busy) begin
            if (pe && !e[m_gnt]) m_busy = 1'b1;
            else if (e[m_gnt]) m_gnt = -1;
        end else if (d) begin
            m_last = m_gnt; m_gnt = -1; m_busy = 1'b0;
        end
    endtask

    initial begin
        // Reset held with pull requests present: nothing may be pulled.
        step('1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);

        // First grant after reset goes to queue 0.
        step(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("first_grant", 32'(grant), 32'h1);
        step(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("busy_after_pull", 32'(busy), 1);
        step(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);

        // Fair rotation with all queues non-empty.
        step('1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            #1 check("rr_order", 32'(grant_id), 32'(r % NREQ));
            step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Done and PullEn together in BUSY: Done wins, no second pull.
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        #1 check("done_pull_idle", 32'(busy), 0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("next_after_done", 32'(grant_id), 2);

        // Granted queue 2 drains before a pull: drop back without moving priority.
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("drained_grant", 32'(grant), 0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("same_position", 32'(grant_id), 2);

        // Reset while busy on queue 3.
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("busy_gid3", 32'(grant_id), 3);
        step(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 check("rst_mid_busy", 32'(busy), 0);
        step(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("grant_after_rst", 32'(grant), 32'h1);

        // Done while granted but not pulled is ignored.
        step(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("done_in_grant", 32'(grant), 32'h1);
        step(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);

        // Power-off clear behaves like reset.
        step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("pwr_off_grant", 32'(grant), 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(NREQ'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
